dual_rail_tx: RTL and testbench

DUAL_RAIL_TX -- requirements
Module: dual_rail_tx

---
 rtl/dual_rail_tx.sv | 182 ++++++++++++++++++
 tb/tb_dual_rail_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dual_rail_tx.sv
// ---------------------------------------------------------------------------
// dual_rail_tx
//
// Purpose: converts single-rail words into a four-phase, return-to-zero
// dual-rail channel. Each accepted word goes out as DATA (d_t = word,
// d_f = ~word). The block then waits for the receiver's ack to rise and
// returns the channel to NULL. It then waits for ack to fall before it
// accepts the next word. The ack input is asynchronous and is synchronised
// locally before the FSM uses it.
//
// Optional feature: define DRTX_TIMEOUT_EN to add an ack-wait counter.
// When the counter reaches TIMEOUT, it sets the sticky err flag.
// Without the macro, err is constant 0.
//
// Parameters:
//   WIDTH       - single-rail word width / number of dual-rail pairs
//   SYNC_STAGES - ack synchroniser depth (2..4)
//   TIMEOUT     - ack-wait limit in clk cycles (DRTX_TIMEOUT_EN only)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   producer offers in_data
//   in_ready   out  block can accept a word (IDLE and ack_s low)
//   in_data    in   WIDTH-bit word to send
//   d_t        out  true rails (registered)
//   d_f        out  false rails (registered)
//   ack        in   asynchronous completion from the receiver
//   sent_count out  completed four-phase handshakes, wraps at 16 bits
//   err        out  sticky ack-timeout flag
// ---------------------------------------------------------------------------
module dual_rail_tx #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] d_t,
    output logic [WIDTH-1:0] d_f,
    input  logic             ack,
    output logic [15:0]      sent_count,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RTZ  = 2'd2
    } state_t;

    // Reject parameter values the hardware cannot support.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT < 1) begin : g_param_check
        $error("dual_rail_tx: SYNC_STAGES must be 2..4 and TIMEOUT >= 1");
    end

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic [WIDTH-1:0]       dt_q, dt_d;
    logic [WIDTH-1:0]       df_q, df_d;
    logic [15:0]            count_q, count_d;

    // Shift register synchroniser for the asynchronous ack.
    // The FSM only ever looks at the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // FSM state, rail and handshake-count registers.
    // dt_q doubles as the captured word while in DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dt_q    <= '0;
            df_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            dt_q    <= dt_d;
            df_q    <= df_d;
            count_q <= count_d;
        end
    end

    // Next-state and rail logic. The rails are computed here, one edge
    // ahead, and then registered. Every pair therefore switches on the same
    // edge, and a pair never has both rails high.
    always_comb begin
        state_d  = state_q;
        dt_d     = dt_q;
        df_d     = df_q;
        count_d  = count_q;
        in_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A stale ack from the receiver holds off new words until
                // the receiver returns to NULL.
                in_ready = ~ack_s;
                dt_d     = '0;
                df_d     = '0;
                if (in_valid && !ack_s) begin
                    state_d = DATA;
                    dt_d    = in_data;
                    df_d    = ~in_data;
                end
            end
            DATA: begin
                if (ack_s) begin
                    state_d = RTZ;
                    dt_d    = '0;
                    df_d    = '0;
                end
            end
            RTZ: begin
                dt_d = '0;
                df_d = '0;
                if (!ack_s) begin
                    state_d = IDLE;
                    count_d = count_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                dt_d    = '0;
                df_d    = '0;
            end
        endcase
    end

    assign d_t        = dt_q;
    assign d_f        = df_q;
    assign sent_count = count_q;

`ifdef DRTX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wait_q, wait_d;
    logic             err_q, err_d;

    // Ack-wait counter. It restarts on every state change and otherwise
    // counts cycles spent in DATA or RTZ, stopping at the limit. It only
    // reports through err and never steers the FSM.
    always_comb begin
        wait_d = wait_q;
        err_d  = err_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (state_q != IDLE && wait_q != WAIT_LIMIT) begin
            wait_d = wait_q + 1'b1;
        end
        if (wait_d == WAIT_LIMIT) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dual_rail_tx.sv
// ---------------------------------------------------------------------------
// tb_dual_rail_tx
//
// Directed testbench for dual_rail_tx with WIDTH = 4, SYNC_STAGES = 2 and
// TIMEOUT = 8. Expected values are hand-derived constants. The expected
// err value depends on whether DRTX_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_dual_rail_tx;

`ifdef DRTX_TIMEOUT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [3:0]  d_t;
    logic [3:0]  d_f;
    logic        ack;
    logic [15:0] sent_count;
    logic        err;

    int testsRun;
    int testsFailed;

    dual_rail_tx #(
        .WIDTH      (4),
        .SYNC_STAGES(2),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .d_t       (d_t),
        .d_f       (d_f),
        .ack       (ack),
        .sent_count(sent_count),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic stepEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] data);
        in_valid = valid;
        in_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One complete handshake: accept, ack high, wait, ack low, wait.
    task automatic doHandshake(input logic [3:0] data);
        applyStimulus(1'b1, data);
        stepEdges(1);
        applyStimulus(1'b0, 4'h0);
        ack = 1'b1;
        stepEdges(3);
        ack = 1'b0;
        stepEdges(3);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        ack         = 1'b0;
        applyStimulus(1'b0, 4'h0);

        // Reset values before any clock edge.
        #2;
        checkOutput("rst_d_t",      16'(d_t), 16'h0);
        checkOutput("rst_d_f",      16'(d_f), 16'h0);
        checkOutput("rst_count",    sent_count, 16'h0);
        checkOutput("rst_err",      16'(err), 16'h0);
        checkOutput("rst_in_ready", 16'(in_ready), 16'h1);
        stepEdges(2);
        rst_n = 1'b1;
        stepEdges(1);

        // Single word 1010, with a busy offer of 0110 during DATA.
        applyStimulus(1'b1, 4'b1010);
        checkOutput("idle_ready", 16'(in_ready), 16'h1);
        stepEdges(1);
        checkOutput("w1_d_t",  16'(d_t), 16'b1010);
        checkOutput("w1_d_f",  16'(d_f), 16'b0101);
        checkOutput("w1_ready", 16'(in_ready), 16'h0);
        applyStimulus(1'b1, 4'b0110);
        stepEdges(2);
        checkOutput("busy_d_t",  16'(d_t), 16'b1010);
        checkOutput("busy_d_f",  16'(d_f), 16'b0101);
        checkOutput("busy_ready", 16'(in_ready), 16'h0);
        ack = 1'b1;
        stepEdges(2);
        checkOutput("ack_lat2_d_t", 16'(d_t), 16'b1010);
        stepEdges(1);
        checkOutput("ack_lat3_d_t", 16'(d_t), 16'h0);
        checkOutput("ack_lat3_d_f", 16'(d_f), 16'h0);
        checkOutput("rtz_ready",   16'(in_ready), 16'h0);
        ack = 1'b0;
        stepEdges(2);
        checkOutput("nack_lat2_ready", 16'(in_ready), 16'h0);
        checkOutput("nack_lat2_count", sent_count, 16'd0);
        stepEdges(1);
        checkOutput("nack_lat3_ready", 16'(in_ready), 16'h1);
        checkOutput("nack_lat3_count", sent_count, 16'd1);
        checkOutput("no_accept_on_rtz_edge", 16'(d_t), 16'h0);
        stepEdges(1);
        checkOutput("w2_d_t", 16'(d_t), 16'b0110);
        checkOutput("w2_d_f", 16'(d_f), 16'b1001);
        applyStimulus(1'b0, 4'h0);
        ack = 1'b1;
        stepEdges(3);
        checkOutput("w2_null_d_t", 16'(d_t), 16'h0);
        ack = 1'b0;
        stepEdges(3);
        checkOutput("w2_count", sent_count, 16'd2);

        // Wrap: start the counter at 65535, then complete one more handshake.
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        checkOutput("preload_count", sent_count, 16'hFFFF);
        doHandshake(4'b0101);
        checkOutput("wrap_count", sent_count, 16'h0000);
        doHandshake(4'b1100);
        checkOutput("post_wrap_count", sent_count, 16'h0001);

        // Timeout: no ack for 8 cycles in DATA.
        applyStimulus(1'b1, 4'b0011);
        stepEdges(1);
        applyStimulus(1'b0, 4'h0);
        checkOutput("to_d_t", 16'(d_t), 16'b0011);
        stepEdges(7);
        checkOutput("to_err_at7", 16'(err), 16'h0);
        stepEdges(1);
        checkOutput("to_err_at8", 16'(err), 16'(EXP_ERR));
        checkOutput("to_hold_d_t", 16'(d_t), 16'b0011);
        stepEdges(5);
        checkOutput("to_err_sticky", 16'(err), 16'(EXP_ERR));
        checkOutput("to_hold_d_f", 16'(d_f), 16'b1100);
        ack = 1'b1;
        stepEdges(3);
        checkOutput("to_null_d_t", 16'(d_t), 16'h0);
        ack = 1'b0;
        stepEdges(3);
        checkOutput("to_count", sent_count, 16'd2);
        checkOutput("to_err_after", 16'(err), 16'(EXP_ERR));

        // Asynchronous reset in DATA, with ack already high.
        applyStimulus(1'b1, 4'b1001);
        stepEdges(1);
        applyStimulus(1'b0, 4'h0);
        checkOutput("mid_d_t", 16'(d_t), 16'b1001);
        ack = 1'b1;
        stepEdges(1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_d_t",   16'(d_t), 16'h0);
        checkOutput("mid_rst_d_f",   16'(d_f), 16'h0);
        checkOutput("mid_rst_count", sent_count, 16'h0);
        checkOutput("mid_rst_err",   16'(err), 16'h0);
        checkOutput("mid_rst_ready", 16'(in_ready), 16'h1);
        stepEdges(1);
        rst_n = 1'b1;

        // Stale ack after reset: new words are blocked until ack falls.
        stepEdges(3);
        checkOutput("stale_ready", 16'(in_ready), 16'h0);
        checkOutput("stale_count", sent_count, 16'h0);
        stepEdges(10);
        checkOutput("stale_ready_long", 16'(in_ready), 16'h0);
        applyStimulus(1'b1, 4'b1111);
        stepEdges(2);
        checkOutput("stale_no_accept", 16'(d_t), 16'h0);
        ack = 1'b0;
        stepEdges(1);
        checkOutput("stale_drop_lat1", 16'(in_ready), 16'h0);
        stepEdges(1);
        checkOutput("stale_drop_lat2", 16'(in_ready), 16'h1);
        checkOutput("stale_err", 16'(err), 16'h0);
        stepEdges(1);
        checkOutput("stale_w_d_t", 16'(d_t), 16'b1111);
        checkOutput("stale_w_d_f", 16'(d_f), 16'b0000);
        applyStimulus(1'b0, 4'h0);
        ack = 1'b1;
        stepEdges(3);
        ack = 1'b0;
        stepEdges(3);
        checkOutput("stale_final_count", sent_count, 16'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
